// File: rtl/wb_sched.sv
// Write-back scheduler: serialises the E and M destinations of one retired instruction
// onto a single register-file write port, E first, one write per cycle.
module wb_sched #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        i_code,
    input  logic              cnd,
    input  logic [3:0]        ra,
    input  logic [3:0]        rb,
    input  logic [DATA_W-1:0] val_e,
    input  logic [DATA_W-1:0] val_m,
    output logic              rf_we,
    output logic [3:0]        rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  wr_count
);

    localparam logic [3:0] RegNone = 4'hF;
    localparam logic [3:0] RegRsp  = 4'd4;

    typedef enum logic [1:0] {
        StIdle,
        StWrE,
        StWrM,
        StNoWr
    } state_e;

    state_e            r_state;
    state_e            w_state_next;
    logic [3:0]        r_dst_e;
    logic [3:0]        r_dst_m;
    logic [DATA_W-1:0] r_val_e;
    logic [DATA_W-1:0] r_val_m;
    logic [CNT_W-1:0]  r_wr_count;

    logic              w_accept;
    logic [3:0]        w_dst_e_raw;
    logic [3:0]        w_dst_e;
    logic [3:0]        w_dst_m;

    assign req_ready = (r_state == StIdle) && !reset;
    assign w_accept  = req_valid && req_ready;
    assign busy      = (r_state != StIdle);
    assign wr_count  = r_wr_count;

    always_comb begin
        w_dst_e_raw = RegNone;
        case (i_code)
            4'h2:                      w_dst_e_raw = cnd ? rb : RegNone;
            4'h3, 4'h6:                w_dst_e_raw = rb;
            4'h8, 4'h9, 4'hA, 4'hB:    w_dst_e_raw = RegRsp;
            default:                   w_dst_e_raw = RegNone;
        endcase
        w_dst_m = ((i_code == 4'h5) || (i_code == 4'hB)) ? ra : RegNone;
        // popq %rsp: the loaded value must win, so the E write is dropped entirely.
        w_dst_e = ((w_dst_e_raw != RegNone) && (w_dst_e_raw == w_dst_m)) ? RegNone
                                                                          : w_dst_e_raw;
    end

    always_comb begin
        w_state_next = r_state;
        rf_we        = 1'b0;
        rf_waddr     = RegNone;
        rf_wdata     = '0;
        done         = 1'b0;
        case (r_state)
            StIdle: begin
                if (w_accept) begin
                    if (w_dst_e != RegNone) begin
                        w_state_next = StWrE;
                    end else if (w_dst_m != RegNone) begin
                        w_state_next = StWrM;
                    end else begin
                        w_state_next = StNoWr;
                    end
                end
            end
            StWrE: begin
                rf_we    = 1'b1;
                rf_waddr = r_dst_e;
                rf_wdata = r_val_e;
                if (r_dst_m != RegNone) begin
                    w_state_next = StWrM;
                end else begin
                    w_state_next = StIdle;
                    done         = 1'b1;
                end
            end
            StWrM: begin
                rf_we        = 1'b1;
                rf_waddr     = r_dst_m;
                rf_wdata     = r_val_m;
                done         = 1'b1;
                w_state_next = StIdle;
            end
            StNoWr: begin
                done         = 1'b1;
                w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= StIdle;
            r_dst_e    <= RegNone;
            r_dst_m    <= RegNone;
            r_val_e    <= '0;
            r_val_m    <= '0;
            r_wr_count <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_dst_e <= w_dst_e;
                r_dst_m <= w_dst_m;
                r_val_e <= val_e;
                r_val_m <= val_m;
            end
            if (rf_we) begin
                r_wr_count <= r_wr_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_wb_sched.sv
// Scoreboard bench for wb_sched: stimulus pushes expected per-cycle beats, a negedge
// monitor pops and compares them against the write port and status outputs.
module tb_wb_sched;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned CNT_W  = 16;

    logic              clock;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic [3:0]        i_code;
    logic              cnd;
    logic [3:0]        ra;
    logic [3:0]        rb;
    logic [DATA_W-1:0] val_e;
    logic [DATA_W-1:0] val_m;
    logic              rf_we;
    logic [3:0]        rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  wr_count;

    wb_sched #(
        .DATA_W(DATA_W),
        .CNT_W (CNT_W)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .i_code   (i_code),
        .cnd      (cnd),
        .ra       (ra),
        .rb       (rb),
        .val_e    (val_e),
        .val_m    (val_m),
        .rf_we    (rf_we),
        .rf_waddr (rf_waddr),
        .rf_wdata (rf_wdata),
        .busy     (busy),
        .done     (done),
        .wr_count (wr_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic        we;
        logic [3:0]  addr;
        logic [63:0] data;
        logic        done;
    } beat_t;

    beat_t q[$];
    int    checks   = 0;
    int    errors   = 0;
    int    done_cnt = 0;
    bit    seen2    = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic we, input logic [3:0] addr, input logic [63:0] data,
                        input logic dn);
        beat_t b;
        b.we   = we;
        b.addr = addr;
        b.data = data;
        b.done = dn;
        q.push_back(b);
    endtask

    // Waits for req_ready (scrambling fields while busy), presents the request, and
    // returns #1 after the accepting edge.
    task automatic issue(input logic [3:0] ic, input logic c, input logic [3:0] a,
                         input logic [3:0] b, input logic [63:0] ve, input logic [63:0] vm,
                         input bit hold_valid);
        int cyc;
        cyc = 0;
        while (!req_ready && cyc < 20) begin
            i_code = 4'h3;
            cnd    = 1'b1;
            ra     = 4'($urandom_range(0, 14));
            rb     = 4'($urandom_range(0, 14));
            val_e  = {32'hDEAD_0000, $urandom};
            val_m  = {32'hBEEF_0000, $urandom};
            @(posedge clock);
            #1;
            cyc++;
        end
        if (cyc >= 20) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: req_ready stuck low at %0t", $time);
        end
        req_valid = 1'b1;
        i_code    = ic;
        cnd       = c;
        ra        = a;
        rb        = b;
        val_e     = ve;
        val_m     = vm;
        @(posedge clock);
        #1;
        if (!hold_valid) req_valid = 1'b0;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    always @(negedge clock) begin
        beat_t b;
        if (rf_we && rf_waddr == 4'd2) seen2 = 1'b1;
        if (done) done_cnt++;
        if (busy === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: we=%0b addr=0x%0h done=%0b with empty queue",
                         rf_we, rf_waddr, done);
            end else begin
                b = q.pop_front();
                chk("beat_we", 64'(rf_we), 64'(b.we));
                chk("beat_done", 64'(done), 64'(b.done));
                if (b.we) begin
                    chk("beat_addr", 64'(rf_waddr), 64'(b.addr));
                    chk("beat_data", rf_wdata, b.data);
                end
            end
        end else if (busy === 1'b0 && !reset) begin
            chk("idle_we", 64'(rf_we), 64'd0);
            chk("idle_done", 64'(done), 64'd0);
        end
    end

    initial begin
        int wait_cyc;
        reset     = 1'b1;
        req_valid = 1'b0;
        i_code    = '0;
        cnd       = 1'b0;
        ra        = '0;
        rb        = '0;
        val_e     = '0;
        val_m     = '0;
        cycles(2);

        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_we", 64'(rf_we), 64'd0);
        chk("rst_waddr", 64'(rf_waddr), 64'hF);
        chk("rst_wdata", rf_wdata, 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_count", 64'(wr_count), 64'd0);
        reset = 1'b0;
        #1;
        chk("ready_after_rst", 64'(req_ready), 64'd1);

        // irmovq
        push(1'b1, 4'd3, 64'h1234, 1'b1);
        issue(4'h3, 1'b0, 4'hF, 4'd3, 64'h1234, 64'h0, 1'b0);
        cycles(1);
        chk("irmovq_ready", 64'(req_ready), 64'd1);
        chk("irmovq_count", 64'(wr_count), 64'd1);

        // popq %rdx
        push(1'b1, 4'd4, 64'h108, 1'b0);
        push(1'b1, 4'd2, 64'hAB, 1'b1);
        issue(4'hB, 1'b0, 4'd2, 4'hF, 64'h108, 64'hAB, 1'b0);
        cycles(2);
        chk("popq_count", 64'(wr_count), 64'd3);

        // popq %rsp: single M write
        push(1'b1, 4'd4, 64'h55, 1'b1);
        issue(4'hB, 1'b0, 4'd4, 4'hF, 64'h108, 64'h55, 1'b0);
        cycles(1);
        chk("poprsp_count", 64'(wr_count), 64'd4);

        // cmov not taken, halt, rmmovq: no writes
        push(1'b0, 4'hF, 64'h0, 1'b1);
        issue(4'h2, 1'b0, 4'd1, 4'd5, 64'h77, 64'h0, 1'b0);
        push(1'b0, 4'hF, 64'h0, 1'b1);
        issue(4'h0, 1'b0, 4'd1, 4'd5, 64'h77, 64'h0, 1'b0);
        push(1'b0, 4'hF, 64'h0, 1'b1);
        issue(4'h4, 1'b0, 4'd1, 4'd5, 64'h77, 64'h66, 1'b0);
        cycles(1);
        chk("nowr_count", 64'(wr_count), 64'd4);

        // cmov taken, mrmovq
        push(1'b1, 4'd5, 64'h77, 1'b1);
        issue(4'h2, 1'b1, 4'd1, 4'd5, 64'h77, 64'h0, 1'b0);
        push(1'b1, 4'd7, 64'h99, 1'b1);
        issue(4'h5, 1'b0, 4'd7, 4'd1, 64'h10, 64'h99, 1'b0);
        cycles(1);
        chk("cmov_mr_count", 64'(wr_count), 64'd6);

        // reset in the WRE cycle of a popq
        cycles(1);
        seen2 = 1'b0;
        push(1'b1, 4'd4, 64'h108, 1'b0);
        push(1'b1, 4'd2, 64'hCC, 1'b1);
        issue(4'hB, 1'b0, 4'd2, 4'hF, 64'h108, 64'hCC, 1'b0);
        reset = 1'b1;
        cycles(1);
        chk("rstmid_busy", 64'(busy), 64'd0);
        chk("rstmid_we", 64'(rf_we), 64'd0);
        chk("rstmid_count", 64'(wr_count), 64'd0);
        chk("rstmid_ready_low", 64'(req_ready), 64'd0);
        q.delete();
        reset = 1'b0;
        #1;
        chk("rstmid_ready", 64'(req_ready), 64'd1);
        cycles(3);
        chk("rstmid_no_addr2", 64'(seen2), 64'd0);

        // back-to-back stream with req_valid held high
        done_cnt = 0;
        push(1'b1, 4'd9, 64'h11, 1'b1);
        issue(4'h3, 1'b0, 4'hF, 4'd9, 64'h11, 64'h0, 1'b1);
        push(1'b1, 4'd4, 64'h200, 1'b0);
        push(1'b1, 4'd6, 64'h33, 1'b1);
        issue(4'hB, 1'b0, 4'd6, 4'hF, 64'h200, 64'h33, 1'b1);
        push(1'b1, 4'd4, 64'h1F8, 1'b1);
        issue(4'h8, 1'b0, 4'hF, 4'hF, 64'h1F8, 64'h0, 1'b1);
        req_valid = 1'b0;
        wait_cyc = 0;
        while (q.size() != 0 && wait_cyc < 20) begin
            cycles(1);
            wait_cyc++;
        end
        cycles(2);
        chk("b2b_queue_drained", 64'(q.size()), 64'd0);
        chk("b2b_done_pulses", 64'(done_cnt), 64'd3);
        chk("b2b_count", 64'(wr_count), 64'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_sched.md
# wb_sched

Write-back scheduler for the SEQ datapath's register file. Accepts one completed instruction's write-back request: `i_code`, `cnd`, `ra`, `rb`, `val_e`, `val_m`. Decodes the E and M destinations and serialises them onto a single register-file write port, one write per cycle. It sits between execute/memory and the register file, replacing direct dual writes so `popq` and other dual-destination cases are ordered deterministically.

## Interface

Parameters:
- `DATA_W`, 64, register data width
- `CNT_W`, 16, width of the write counter

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - `clock`  in  1  system clock; all state changes on its rising edge
  - `reset`  in  1  synchronous, active-high reset
- Request handshake:
  - `req_valid`  in  1  write-back request present
  - `req_ready`  out  1  scheduler can accept a request
- Request fields (sampled only on accept):
  - `i_code`  in  4  instruction code
  - `cnd`  in  1  condition result, used by `cmovXX`
  - `ra`, `rb`  in  4 each  register specifiers
  - `val_e`, `val_m`  in  DATA_W each  ALU result and memory result
- Register-file write port:
  - `rf_we`  out  1  write enable
  - `rf_waddr`  out  4  write address; 4'hF = none
  - `rf_wdata`  out  DATA_W  write data
- Status:
  - `busy`  out  1  high whenever state is not IDLE
  - `done`  out  1  one-cycle pulse in the final cycle of a request
  - `wr_count`  out  CNT_W  total register writes issued; wraps at 2^CNT_W

## Operation

- Accept occurs when `req_valid && req_ready`. `req_ready` = (state == IDLE) and not `reset`.
- On accept, latch the request fields and decode the destinations:
  - dstE: `rb` for 2 (only if `cnd`=1), 3, 6; 4'd4 for 8, 9, 10, 11; otherwise 4'hF.
  - dstM: `ra` for 5 and 11; otherwise 4'hF.
  - A destination equal to 4'hF means no write.
- Same-register rule: if dstE == dstM and both are valid (e.g. `popq %rsp`), drop the E write. M wins, so only one write is issued.
- FSM states are IDLE, WRE, WRM, NOWR.
  - IDLE, on accept: go to WRE if E is valid, else WRM if M is valid, else NOWR.
  - WRE: `rf_we`=1, `rf_waddr`=dstE, `rf_wdata`=latched `val_e`. Next state is WRM if M is valid, else IDLE with `done`=1.
  - WRM: `rf_we`=1, `rf_waddr`=dstM, `rf_wdata`=latched `val_m`, `done`=1. Next state IDLE.
  - NOWR: `rf_we`=0, `done`=1. Next state IDLE.
- Write order is always E before M.
- `wr_count` increments by 1 in every cycle with `rf_we`=1.
- Outputs depend only on registered state and latched fields. There is no combinational path from request inputs to `rf_*`, `done` or `busy`.
- Undefined or no-write `i_code` values (0, 1, 4, 7, 12–15) take the NOWR path.

## Timing

- Reset values:
  - state IDLE
  - `rf_we`=0, `rf_waddr`=4'hF, `rf_wdata`=0
  - `done`=0, `busy`=0
  - `wr_count`=0
  - `req_ready`=0 during the reset cycle, 1 in the first cycle after reset deasserts
- Latency from accept (cycle N):
  - first write occurs in cycle N+1
  - second write, if any, in cycle N+2
  - `done` is asserted in the last of these cycles
- Occupancy per request: 1 cycle for a single write or NOWR, 2 cycles for a dual write.
  - `req_ready` returns high the cycle after `done`.
  - Peak throughput is one request every 2 cycles (single write) or 3 cycles (dual write).
- While `busy`, `req_valid` is ignored and input fields may change freely. Nothing is re-sampled.
- Reset mid-request: the FSM goes to IDLE in the cycle after `reset` is sampled. No pending write (including a queued M) is issued. `done` is not pulsed. `wr_count` clears.
- `wr_count` wraps from 2^CNT_W−1 to 0 without saturating.
- `rf_waddr` and `rf_wdata` are don't-care while `rf_we`=0, except in the reset state.

## Test plan

- irmovq: `i_code`=3, `rb`=3, `val_e`=0x1234 accepted at cycle N.
  - Required: cycle N+1 has `rf_we`=1, addr 3, data 0x1234, `done`=1.
  - `req_ready`=1 at N+2; `wr_count`=1.
- popq to a non-stack register: `i_code`=11, `ra`=2, `val_e`=0x108, `val_m`=0xAB.
  - Required: N+1 writes addr 4, data 0x108. N+2 writes addr 2, data 0xAB, `done`=1.
  - `wr_count` advances by 2.
- popq %rsp: `i_code`=11, `ra`=4, `val_e`=0x108, `val_m`=0x55.
  - Required: exactly one write, at N+1, addr 4, data 0x55, `done`=1. No WRE cycle.
- cmovXX not taken: `i_code`=2, `cnd`=0, `rb`=5. Also `i_code`=0 (halt) and `i_code`=4 (rmmovq).
  - Required: `rf_we` stays 0; `done` pulses at N+1; `wr_count` unchanged.
- Reset mid-request: popq with `ra`=2, `reset` asserted in the WRE cycle.
  - Required: addr 2 is never written; `busy`=0 and `rf_we`=0 in the following cycle; `wr_count`=0; `req_ready`=1 once reset drops.
- Back-to-back stream: `req_valid` held high across irmovq, popq, call, with fields changing every cycle.
  - Required: each request is accepted only when `req_ready`=1.
  - Writes: (rb, val_e); (4, val_e) then (ra, val_m); (4, val_e), in that order.
  - Three `done` pulses; final `wr_count`=4.
